// File: rtl/regfile_wb_port_pkg.sv
// Shared register-file constants for the MIPS pipeline: GPR geometry and named registers.
// The decoder and hazard unit import the same names.
package regfile_wb_port_pkg;

    localparam int REG_AW    = 5;
    localparam int REG_DW    = 32;
    localparam int REG_CNT_W = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_SP   = 5'd29;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

    typedef logic [REG_AW-1:0] regIdx_t;

endpackage

// File: rtl/regfile_wb_port_if.sv
// Write-back stream, ID-stage read ports and the debug write counter of the register file.
// The master is the pipeline side and the slave is the register file.
interface regfile_wb_port_if
    import regfile_wb_port_pkg::*;
#(
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW,
    parameter int CNT_W = REG_CNT_W
);
    logic             RegWrite_wb;
    logic [AW-1:0]    WriteReg_wb;
    logic [DW-1:0]    RegWriteData_wb;
    logic [AW-1:0]    ReadReg1_id;
    logic [AW-1:0]    ReadReg2_id;
    logic [DW-1:0]    ReadData1_id;
    logic [DW-1:0]    ReadData2_id;
    logic [CNT_W-1:0] WriteCount;

    modport master (
        output RegWrite_wb, WriteReg_wb, RegWriteData_wb, ReadReg1_id, ReadReg2_id,
        input  ReadData1_id, ReadData2_id, WriteCount
    );

    modport slave (
        input  RegWrite_wb, WriteReg_wb, RegWriteData_wb, ReadReg1_id, ReadReg2_id,
        output ReadData1_id, ReadData2_id, WriteCount
    );
endinterface

// File: rtl/regfile_read_port.sv
// A single combinational operand read port: $zero forcing, then an optional write-through bypass.
module regfile_read_port
    import regfile_wb_port_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] storeData,
    input  logic          bypassEn,
    input  logic [AW-1:0] bypassAddr,
    input  logic [DW-1:0] bypassData,
    output logic [DW-1:0] data
);

    // $zero wins over the bypass, so a write aimed at r0 can never leak out.
    always_comb begin
        data = storeData;
        if (addr == AW'(REG_ZERO)) begin
            data = '0;
        end else if (bypassEn && (bypassAddr == addr)) begin
            data = bypassData;
        end
    end

endmodule

// File: rtl/regfile_wb_port.sv
// This is the 32 x 32 GPR file. It takes the WB write stream and serves the ID read ports.
// The build macro REGFILE_WB_BYPASS_EN enables a same-cycle WB->ID write-through bypass.
module regfile_wb_port
    import regfile_wb_port_pkg::*;
#(
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW,
    parameter int CNT_W = REG_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    regfile_wb_port_if.slave bus
);

    localparam int NREGS = 2 ** AW;

    logic [DW-1:0]    regFileReg [NREGS];
    logic [CNT_W-1:0] writeCountReg;
    logic             doWrite;
    logic             bypassEn;
    logic [AW-1:0]    rdAddr [2];
    logic [DW-1:0]    rdData [2];

    assign doWrite = bus.RegWrite_wb && (bus.WriteReg_wb != AW'(REG_ZERO));

`ifdef REGFILE_WB_BYPASS_EN
    // During reset the storage is being cleared, so outputs must follow storage.
    assign bypassEn = bus.RegWrite_wb && rst_n;
`else
    assign bypassEn = 1'b0;
`endif

    // Entry 0 is only ever cleared, so storage itself also reads 0 for r0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regFileReg[i] <= '0;
            end
            writeCountReg <= '0;
        end else if (doWrite) begin
            regFileReg[bus.WriteReg_wb] <= bus.RegWriteData_wb;
            writeCountReg               <= writeCountReg + CNT_W'(1);
        end
    end

    assign rdAddr[0] = bus.ReadReg1_id;
    assign rdAddr[1] = bus.ReadReg2_id;

    for (genvar gi = 0; gi < 2; gi++) begin : gReadPort
        regfile_read_port #(
            .DW(DW),
            .AW(AW)
        ) uReadPort (
            .addr      (rdAddr[gi]),
            .storeData (regFileReg[rdAddr[gi]]),
            .bypassEn  (bypassEn),
            .bypassAddr(bus.WriteReg_wb),
            .bypassData(bus.RegWriteData_wb),
            .data      (rdData[gi])
        );
    end

    assign bus.ReadData1_id = rdData[0];
    assign bus.ReadData2_id = rdData[1];
    assign bus.WriteCount   = writeCountReg;

endmodule
